dcache_flush_ctrl: RTL and testbench

DCACHE_FLUSH_CTRL -- requirements
Module: dcache_flush_ctrl

---
 rtl/dcache_flush_ctrl_if.sv | 40 ++++
 rtl/dcache_flush_ctrl.sv | 82 ++++++++
 tb/tb_dcache_flush_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_flush_ctrl_if.sv
// dcache_flush_ctrl_if: request, memblock-steal and main-memory signals of the flush controller
interface dcache_flush_ctrl_if #(
  parameter int DATABITS    = 32,
  parameter int ADDRBITS    = 5,
  parameter int LINEBITS    = 3,
  parameter int MEMADDRBITS = 32
);
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_writeback;
  logic                         req_fill;
  logic [ADDRBITS-LINEBITS-1:0] req_line;
  logic [MEMADDRBITS-1:0]       req_wb_base;
  logic [MEMADDRBITS-1:0]       req_fill_base;
  logic                         done;
  logic                         busy;
  logic                         flush_mode;
  logic [ADDRBITS-1:0]          flush_addr;
  logic [DATABITS-1:0]          flush_in;
  logic                         flush_we;
  logic [DATABITS-1:0]          mb_rdata;
  logic                         mem_req;
  logic                         mem_we;
  logic [MEMADDRBITS-1:0]       mem_addr;
  logic [DATABITS-1:0]          mem_wdata;
  logic                         mem_ack;
  logic [DATABITS-1:0]          mem_rdata;
  modport slave (
    input  req_valid, req_writeback, req_fill, req_line, req_wb_base, req_fill_base,
           mb_rdata, mem_ack, mem_rdata,
    output req_ready, done, busy, flush_mode, flush_addr, flush_in, flush_we,
           mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_writeback, req_fill, req_line, req_wb_base, req_fill_base,
           mb_rdata, mem_ack, mem_rdata,
    input  req_ready, done, busy, flush_mode, flush_addr, flush_in, flush_we,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_flush_ctrl.sv
// dcache_flush_ctrl: writes back and/or refills one cache line between the memblock and main memory
module dcache_flush_ctrl #(
  parameter int DATABITS    = 32,
  parameter int ADDRBITS    = 5,
  parameter int LINEBITS    = 3,
  parameter int MEMADDRBITS = 32
) (
  input logic              clk,
  input logic              reset_n,
  dcache_flush_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WB_RD, WB_CAP, WB_WR, FILL_RQ, FILL_WR, DONE} state_t;
  localparam logic [LINEBITS-1:0] LAST = '1;
  localparam logic [MEMADDRBITS-1:0] BYTES = MEMADDRBITS'(DATABITS / 8);
  state_t                       state, state_n;
  logic [LINEBITS-1:0]          cnt, cnt_n;
  logic [ADDRBITS-LINEBITS-1:0] line;
  logic [MEMADDRBITS-1:0]       wb_base, fill_base, offs;
  logic                         wb, fill, last;
  logic [DATABITS-1:0]          wdata_q, fin_q;
  assign last = cnt == LAST;
  assign offs = MEMADDRBITS'(cnt) * BYTES;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      line      <= '0;
      wb_base   <= '0;
      fill_base <= '0;
      wb        <= 1'b0;
      fill      <= 1'b0;
      wdata_q   <= '0;
      fin_q     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && bus.req_valid) begin
        line      <= bus.req_line;
        wb_base   <= bus.req_wb_base;
        fill_base <= bus.req_fill_base;
        wb        <= bus.req_writeback;
        fill      <= bus.req_fill;
      end
      if (state == WB_CAP) wdata_q <= bus.mb_rdata;
      if (state == FILL_RQ && bus.mem_ack) fin_q <= bus.mem_rdata;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE:    if (bus.req_valid) begin
                 cnt_n   = '0;
                 state_n = bus.req_writeback ? WB_RD : bus.req_fill ? FILL_RQ : DONE;
               end
      WB_RD:   state_n = WB_CAP;
      WB_CAP:  state_n = WB_WR;
      WB_WR:   if (bus.mem_ack) begin
                 cnt_n   = last ? '0 : cnt + 1'b1;
                 state_n = !last ? WB_RD : fill ? FILL_RQ : DONE;
               end
      FILL_RQ: if (bus.mem_ack) state_n = FILL_WR;
      FILL_WR: begin
                 cnt_n   = last ? '0 : cnt + 1'b1;
                 state_n = last ? DONE : FILL_RQ;
               end
      default: state_n = IDLE;
    endcase
  end
  assign bus.req_ready  = state == IDLE;
  assign bus.busy       = state != IDLE;
  // done and flush_we are masked by reset so an aborted cycle never completes or writes
  assign bus.done       = state == DONE && reset_n;
  assign bus.flush_we   = state == FILL_WR && reset_n;
  assign bus.flush_mode = state inside {WB_RD, WB_CAP, WB_WR, FILL_RQ, FILL_WR};
  assign bus.flush_addr = bus.flush_mode ? {line, cnt} : '0;
  assign bus.flush_in   = fin_q;
  assign bus.mem_req    = state == WB_WR || state == FILL_RQ;
  assign bus.mem_we     = state == WB_WR;
  assign bus.mem_addr   = state == WB_WR ? wb_base + offs : state == FILL_RQ ? fill_base + offs : '0;
  assign bus.mem_wdata  = wdata_q;
endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// tb_dcache_flush_ctrl: directed checks of writeback, fill, combined, empty, busy and reset scenarios
module tb_dcache_flush_ctrl;
  localparam int DW = 32, AW = 5, LB = 3, MW = 32;
  logic clk = 0, reset_n = 0;
  always #5 clk = ~clk;
  dcache_flush_ctrl_if #(.DATABITS(DW), .ADDRBITS(AW), .LINEBITS(LB), .MEMADDRBITS(MW)) bus();
  dcache_flush_ctrl #(.DATABITS(DW), .ADDRBITS(AW), .LINEBITS(LB), .MEMADDRBITS(MW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  int nchk = 0, nfail = 0;
  int ack_delay = 0, wcnt = 0, cyc = 0;
  logic force_ack = 0;
  // memory acks after ack_delay waiting cycles; read data encodes the byte address
  assign bus.mem_ack   = force_ack | (bus.mem_req && wcnt >= ack_delay);
  assign bus.mem_rdata = 32'hF000_0000 + bus.mem_addr;
  always @(posedge clk) begin
    cyc          <= cyc + 1;
    wcnt         <= (bus.mem_req && !bus.mem_ack) ? wcnt + 1 : 0;
    bus.mb_rdata <= 32'hA000 + 32'(bus.flush_addr);
  end
  logic clr = 0, mode_seen, waiting;
  int wr_n, rd_n, fw_n, done_n, acc_cyc, done_cyc, late_wr, unstable;
  logic [31:0] held, wr_a[16], wr_d[16], fw_a[16], fw_d[16];
  always @(negedge clk) begin
    if (clr) begin
      wr_n <= 0; rd_n <= 0; fw_n <= 0; done_n <= 0; acc_cyc <= 0; done_cyc <= 0;
      late_wr <= 0; unstable <= 0; mode_seen <= 0; waiting <= 0; held <= 0;
    end else begin
      if (bus.req_valid && bus.req_ready) acc_cyc <= cyc;
      if (bus.flush_mode) mode_seen <= 1;
      if (bus.mem_req && waiting && bus.mem_addr !== held) unstable <= unstable + 1;
      waiting <= bus.mem_req && !bus.mem_ack;
      held    <= bus.mem_addr;
      if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
        if (rd_n > 0) late_wr <= late_wr + 1;
        if (wr_n < 16) begin wr_a[wr_n] <= bus.mem_addr; wr_d[wr_n] <= bus.mem_wdata; end
        wr_n <= wr_n + 1;
      end
      if (bus.mem_req && bus.mem_ack && !bus.mem_we) rd_n <= rd_n + 1;
      if (bus.flush_we) begin
        if (fw_n < 16) begin fw_a[fw_n] <= 32'(bus.flush_addr); fw_d[fw_n] <= bus.flush_in; end
        fw_n <= fw_n + 1;
      end
      if (bus.done) begin done_n <= done_n + 1; done_cyc <= cyc; end
    end
  end
  task automatic clear_mon();
    @(posedge clk); #1 clr = 1;
    @(posedge clk); #1 clr = 0;
  endtask
  task automatic send(input logic wb, input logic fl, input logic [1:0] ln, input logic [31:0] wbb, input logic [31:0] fb);
    @(posedge clk); #1;
    bus.req_writeback = wb; bus.req_fill = fl; bus.req_line = ln;
    bus.req_wb_base = wbb; bus.req_fill_base = fb; bus.req_valid = 1;
    @(posedge clk); #1 bus.req_valid = 0;
  endtask
  task automatic wait_done(input int extra);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (done_n != 0) break;
    end
    repeat (extra) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if ({bus.req_ready, bus.busy, bus.done, bus.flush_mode, bus.flush_we, bus.mem_req, bus.mem_we,
         bus.flush_addr, bus.mem_addr, bus.mem_wdata, bus.flush_in} !== {1'b1, 107'b0}) begin
      nfail++; $display("FAIL reset_outputs: ready=%b busy=%b mode=%b mem_req=%b, required ready=1 rest 0",
                        bus.req_ready, bus.busy, bus.flush_mode, bus.mem_req);
    end
    reset_n = 1;
  endtask
  task automatic test_writeback();
    ack_delay = 0; clear_mon();
    send(1, 0, 2, 32'h1000, 32'h0);
    wait_done(3);
    nchk++; if (done_n !== 1) begin nfail++; $display("FAIL wb_done_count: got %0d required 1", done_n); end
    nchk++; if (done_cyc - acc_cyc !== 25) begin nfail++; $display("FAIL wb_latency: got %0d required 25", done_cyc - acc_cyc); end
    nchk++; if ({wr_n, rd_n, fw_n} !== {32'd8, 32'd0, 32'd0}) begin nfail++; $display("FAIL wb_counts: wr=%0d rd=%0d fw=%0d required 8 0 0", wr_n, rd_n, fw_n); end
    for (int i = 0; i < 8; i++) begin
      nchk++;
      if (wr_a[i] !== 32'h1000 + 32'(4*i) || wr_d[i] !== 32'hA000 + 32'(16+i)) begin
        nfail++; $display("FAIL wb_word%0d: addr=%h data=%h required %h %h", i, wr_a[i], wr_d[i], 32'h1000 + 32'(4*i), 32'hA000 + 32'(16+i));
      end
    end
  endtask
  task automatic test_fill_delayed();
    ack_delay = 3; clear_mon();
    send(0, 1, 0, 32'h0, 32'h2000);
    wait_done(3);
    nchk++; if (done_n !== 1) begin nfail++; $display("FAIL fill_done_count: got %0d required 1", done_n); end
    nchk++; if (done_cyc - acc_cyc !== 41) begin nfail++; $display("FAIL fill_latency: got %0d required 41", done_cyc - acc_cyc); end
    nchk++; if ({wr_n, rd_n, fw_n} !== {32'd0, 32'd8, 32'd8}) begin nfail++; $display("FAIL fill_counts: wr=%0d rd=%0d fw=%0d required 0 8 8", wr_n, rd_n, fw_n); end
    nchk++; if (unstable !== 0) begin nfail++; $display("FAIL fill_addr_stable: %0d changes while waiting, required 0", unstable); end
    for (int i = 0; i < 8; i++) begin
      nchk++;
      if (fw_a[i] !== 32'(i) || fw_d[i] !== 32'hF000_2000 + 32'(4*i)) begin
        nfail++; $display("FAIL fill_word%0d: addr=%0d data=%h required %0d %h", i, fw_a[i], fw_d[i], i, 32'hF000_2000 + 32'(4*i));
      end
    end
  endtask
  task automatic test_both();
    ack_delay = 0; clear_mon();
    send(1, 1, 3, 32'h3000, 32'h4000);
    wait_done(3);
    nchk++; if (done_cyc - acc_cyc !== 41) begin nfail++; $display("FAIL both_latency: got %0d required 41", done_cyc - acc_cyc); end
    nchk++; if ({wr_n, fw_n, late_wr} !== {32'd8, 32'd8, 32'd0}) begin nfail++; $display("FAIL both_order: wr=%0d fw=%0d late_wr=%0d required 8 8 0", wr_n, fw_n, late_wr); end
    for (int i = 0; i < 8; i++) begin
      nchk++;
      if (wr_a[i] !== 32'h3000 + 32'(4*i) || wr_d[i] !== 32'hA000 + 32'(24+i) ||
          fw_a[i] !== 32'(24+i) || fw_d[i] !== 32'hF000_4000 + 32'(4*i)) begin
        nfail++; $display("FAIL both_word%0d: wr %h/%h fill %0d/%h", i, wr_a[i], wr_d[i], fw_a[i], fw_d[i]);
      end
    end
  endtask
  task automatic test_none();
    ack_delay = 0; clear_mon();
    send(0, 0, 1, 32'h7000, 32'h8000);
    wait_done(3);
    nchk++; if (done_cyc - acc_cyc !== 1 || done_n !== 1) begin nfail++; $display("FAIL none_latency: got %0d (%0d dones) required 1", done_cyc - acc_cyc, done_n); end
    nchk++; if (mode_seen !== 0 || wr_n + rd_n !== 0) begin nfail++; $display("FAIL none_quiet: mode_seen=%b accesses=%0d required 0 0", mode_seen, wr_n + rd_n); end
  endtask
  task automatic test_busy_ignored();
    ack_delay = 0; clear_mon();
    send(1, 0, 1, 32'h5000, 32'h0);
    repeat (3) @(posedge clk);
    #1; bus.req_writeback = 0; bus.req_fill = 1; bus.req_line = 3; bus.req_fill_base = 32'h9000; bus.req_valid = 1;
    @(posedge clk); #1 bus.req_valid = 0;
    wait_done(30);
    nchk++; if ({done_n, wr_n, fw_n, rd_n} !== {32'd1, 32'd8, 32'd0, 32'd0}) begin nfail++; $display("FAIL busy_ignored: done=%0d wr=%0d fw=%0d rd=%0d required 1 8 0 0", done_n, wr_n, fw_n, rd_n); end
    nchk++; if (wr_a[7] !== 32'h501C || wr_d[7] !== 32'hA00F) begin nfail++; $display("FAIL busy_last_word: %h/%h required 0000501c/0000a00f", wr_a[7], wr_d[7]); end
    clear_mon();
    force_ack = 1;
    repeat (3) @(posedge clk);
    #1;
    nchk++; if ({bus.req_ready, bus.busy, bus.done, bus.flush_mode, bus.mem_req} !== 5'b10000 || done_n !== 0) begin
      nfail++; $display("FAIL spurious_ack: ready=%b busy=%b done=%b mode=%b req=%b dones=%0d required 1 0 0 0 0 0",
                        bus.req_ready, bus.busy, bus.done, bus.flush_mode, bus.mem_req, done_n);
    end
    force_ack = 0;
  endtask
  task automatic test_reset_mid();
    bit hit = 0;
    ack_delay = 3; clear_mon();
    send(0, 1, 0, 32'h0, 32'h2000);
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      hit = bus.mem_req && fw_n == 4;
    end
    nchk++; if (!hit) begin nfail++; $display("FAIL reset_mid_reach: fill word 4 request not seen, fw=%0d", fw_n); end
    reset_n = 0;
    @(posedge clk); #1;
    nchk++;
    if ({bus.req_ready, bus.busy, bus.done, bus.flush_mode, bus.flush_we, bus.mem_req, bus.mem_we,
         bus.flush_addr, bus.mem_addr, bus.mem_wdata, bus.flush_in} !== {1'b1, 107'b0}) begin
      nfail++; $display("FAIL reset_mid_outputs: ready=%b busy=%b mem_req=%b flush_in=%h, required ready=1 rest 0",
                        bus.req_ready, bus.busy, bus.mem_req, bus.flush_in);
    end
    reset_n = 1;
    repeat (20) @(posedge clk);
    #1;
    nchk++; if (done_n !== 0 || fw_n !== 4) begin nfail++; $display("FAIL reset_mid_abort: done=%0d fw=%0d required 0 4", done_n, fw_n); end
    ack_delay = 0; clear_mon();
    send(1, 0, 1, 32'h6000, 32'h0);
    wait_done(3);
    nchk++; if (done_cyc - acc_cyc !== 25 || wr_n !== 8 || wr_d[0] !== 32'hA008) begin
      nfail++; $display("FAIL reset_recover: latency=%0d wr=%0d data0=%h required 25 8 0000a008", done_cyc - acc_cyc, wr_n, wr_d[0]);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid = 0; bus.req_writeback = 0; bus.req_fill = 0; bus.req_line = 0;
    bus.req_wb_base = 0; bus.req_fill_base = 0;
    test_reset();
    test_writeback();
    test_fill_delayed();
    test_both();
    test_none();
    test_busy_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
